// File: rtl/explosion_pkg.sv
// Shared types and geometry helpers for the multi-slot explosion engine.
package explosion_pkg;

  typedef enum logic {
    IDLE   = 1'b0,
    ACTIVE = 1'b1
  } slot_state_t;

  localparam int TILE_LOG2 = 4;

  // Cross-shaped blast membership test. Lower extents clip at 0, and integer
  // arithmetic keeps screen-edge blasts from wrapping to large coordinates.
  function automatic bit in_cross(input int px, input int py, input int cx, input int cy,
                                  input int radius, input int tile);
    int lo_x, hi_x, lo_y, hi_y;
    lo_x = cx - radius * tile;
    lo_y = cy - radius * tile;
    if (lo_x < 0) lo_x = 0;
    if (lo_y < 0) lo_y = 0;
    hi_x = cx + (radius + 1) * tile - 1;
    hi_y = cy + (radius + 1) * tile - 1;
    return ((px >= lo_x) && (px <= hi_x) && (py >= cy) && (py <= cy + tile - 1)) ||
           ((py >= lo_y) && (py <= hi_y) && (px >= cx) && (px <= cx + tile - 1));
  endfunction

  // Tile-sized box at (bx,by) against both arms; touching edges do not count.
  function automatic bit box_hits_cross(input int bx, input int by, input int cx, input int cy,
                                        input int radius, input int tile);
    int lo_x, hi_x, lo_y, hi_y;
    lo_x = cx - radius * tile;
    lo_y = cy - radius * tile;
    if (lo_x < 0) lo_x = 0;
    if (lo_y < 0) lo_y = 0;
    hi_x = cx + (radius + 1) * tile;
    hi_y = cy + (radius + 1) * tile;
    return ((bx < hi_x) && (bx + tile > lo_x) && (by < cy + tile) && (by + tile > cy)) ||
           ((by < hi_y) && (by + tile > lo_y) && (bx < cx + tile) && (bx + tile > cx));
  endfunction

endpackage

// File: rtl/explosion_slot.sv
// One explosion slot: lifetime FSM, centre registers and combinational hit tests.
// Player overlap logic exists only when PLAYER_HIT_EN is defined.
module explosion_slot
  import explosion_pkg::*;
#(
  parameter int RADIUS     = 3,
  parameter int TILE       = 16,
  parameter int LIFE_TICKS = 60,
  parameter int CW         = 10
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    tick_i,
  input  logic                    alloc_i,
  input  logic [CW-1:0]           start_x_i,
  input  logic [CW-1:0]           start_y_i,
  input  logic [CW-1:0]           v_x_i,
  input  logic [CW-1:0]           v_y_i,
  input  logic [CW-1:0]           b_x_i,
  input  logic [CW-1:0]           b_y_i,
  output logic                    active_o,
  output logic                    expire_o,
  output logic                    hit_o,
  output logic [$clog2(TILE)-1:0] row_o,
  output logic [$clog2(TILE)-1:0] col_o,
  output logic                    player_hit_o
);

  localparam int TL = $clog2(TILE);
  localparam int TW = $clog2(LIFE_TICKS + 1);

  slot_state_t   state_q, state_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [CW-1:0] cx_q, cx_d, cy_q, cy_d;

  assign active_o = (state_q == ACTIVE);
  assign expire_o = active_o && tick_i && (timer_q == '0);

  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    cx_d    = cx_q;
    cy_d    = cy_q;
    case (state_q)
      IDLE: begin
        if (alloc_i) begin
          state_d = ACTIVE;
          timer_d = TW'(LIFE_TICKS - 1);
          cx_d    = start_x_i;
          cy_d    = start_y_i;
        end
      end
      ACTIVE: begin
        if (tick_i) begin
          if (timer_q == '0) state_d = IDLE;
          else               timer_d = timer_q - TW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      timer_q <= '0;
      cx_q    <= '0;
      cy_q    <= '0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      cx_q    <= cx_d;
      cy_q    <= cy_d;
    end
  end

  assign hit_o = active_o && in_cross(int'(v_x_i), int'(v_y_i), int'(cx_q), int'(cy_q),
                                      RADIUS, TILE);
  // Centres are tile-aligned, so only the low bits matter for the offset.
  assign row_o = v_y_i[TL-1:0] - cy_q[TL-1:0];
  assign col_o = v_x_i[TL-1:0] - cx_q[TL-1:0];

`ifdef PLAYER_HIT_EN
  assign player_hit_o = active_o && box_hits_cross(int'(b_x_i), int'(b_y_i), int'(cx_q),
                                                   int'(cy_q), RADIUS, TILE);
`else
  logic unused_b;
  assign unused_b     = ^{b_x_i, b_y_i};
  assign player_hit_o = 1'b0;
`endif

endmodule

// File: rtl/explosion_engine.sv
// Multi-slot explosion manager: slot allocation, lowest-index priority mux and
// registered pixel/done/player outputs. Optional player hit via PLAYER_HIT_EN.
module explosion_engine
  import explosion_pkg::*;
#(
  parameter int N_SLOTS    = 4,
  parameter int RADIUS     = 3,
  parameter int TILE       = 1 << TILE_LOG2,
  parameter int LIFE_TICKS = 60,
  parameter int CW         = 10
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    tick,
  input  logic                    start_valid,
  output logic                    start_ready,
  input  logic [CW-1:0]           start_x,
  input  logic [CW-1:0]           start_y,
  input  logic [CW-1:0]           v_x,
  input  logic [CW-1:0]           v_y,
  input  logic [CW-1:0]           b_x,
  input  logic [CW-1:0]           b_y,
  output logic                    explosion_on,
  output logic [$clog2(TILE)-1:0] sprite_row,
  output logic [$clog2(TILE)-1:0] sprite_col,
  output logic [N_SLOTS-1:0]      active_mask,
  output logic                    done_pulse,
  output logic                    player_hit
);

  localparam int TL = $clog2(TILE);

  logic [N_SLOTS-1:0] active_w, expire_w, hit_w, ph_w, grant;
  logic [TL-1:0]      row_w [N_SLOTS];
  logic [TL-1:0]      col_w [N_SLOTS];
  logic [TL-1:0]      row_d, col_d, row_q, col_q;
  logic               on_q, done_q;

  generate
    for (genvar gi = 0; gi < N_SLOTS; gi++) begin : g_slot
      explosion_slot #(
        .RADIUS(RADIUS), .TILE(TILE), .LIFE_TICKS(LIFE_TICKS), .CW(CW)
      ) u_slot (
        .clk(clk), .reset(reset), .tick_i(tick), .alloc_i(grant[gi]),
        .start_x_i(start_x), .start_y_i(start_y),
        .v_x_i(v_x), .v_y_i(v_y), .b_x_i(b_x), .b_y_i(b_y),
        .active_o(active_w[gi]), .expire_o(expire_w[gi]), .hit_o(hit_w[gi]),
        .row_o(row_w[gi]), .col_o(col_w[gi]), .player_hit_o(ph_w[gi])
      );
    end
  endgenerate

  // A slot expiring this cycle still reads as busy, so it cannot be re-granted.
  assign start_ready = ~&active_w;

  always_comb begin
    grant = '0;
    for (int i = N_SLOTS - 1; i >= 0; i--) begin
      if (!active_w[i]) grant = N_SLOTS'(1) << i;
    end
    if (!start_valid) grant = '0;
  end

  always_comb begin
    row_d = '0;
    col_d = '0;
    for (int i = N_SLOTS - 1; i >= 0; i--) begin
      if (hit_w[i]) begin
        row_d = row_w[i];
        col_d = col_w[i];
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      on_q   <= 1'b0;
      row_q  <= '0;
      col_q  <= '0;
      done_q <= 1'b0;
    end else begin
      on_q   <= |hit_w;
      row_q  <= row_d;
      col_q  <= col_d;
      done_q <= |expire_w;
    end
  end

  assign explosion_on = on_q;
  assign sprite_row   = row_q;
  assign sprite_col   = col_q;
  assign done_pulse   = done_q;
  assign active_mask  = active_w;

`ifdef PLAYER_HIT_EN
  logic ph_q;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) ph_q <= 1'b0;
    else       ph_q <= |ph_w;
  end
  assign player_hit = ph_q;
`else
  logic unused_ph;
  assign unused_ph  = ^ph_w;
  assign player_hit = 1'b0;
`endif

endmodule

// File: tb/tb_explosion_engine.sv
// Directed bench for explosion_engine with a pixel-path expectation queue.
module tb_explosion_engine;

`ifdef PLAYER_HIT_EN
  localparam bit PH_EN = 1'b1;
`else
  localparam bit PH_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       tick = 1'b0;
  logic       start_valid = 1'b0;
  logic       start_ready;
  logic [9:0] start_x = '0, start_y = '0;
  logic [9:0] v_x = '0, v_y = '0;
  logic [9:0] b_x = 10'd600, b_y = 10'd600;
  logic       explosion_on;
  logic [3:0] sprite_row, sprite_col;
  logic [3:0] active_mask;
  logic       done_pulse;
  logic       player_hit;

  int checks = 0;
  int errors = 0;

  typedef struct {
    bit       on;
    bit [3:0] row;
    bit [3:0] col;
    bit       ph;
  } pexp_t;
  pexp_t sb[$];

  explosion_engine #(
    .N_SLOTS(4), .RADIUS(3), .TILE(16), .LIFE_TICKS(2), .CW(10)
  ) dut (
    .clk(clk), .reset(reset), .tick(tick),
    .start_valid(start_valid), .start_ready(start_ready),
    .start_x(start_x), .start_y(start_y),
    .v_x(v_x), .v_y(v_y), .b_x(b_x), .b_y(b_y),
    .explosion_on(explosion_on), .sprite_row(sprite_row), .sprite_col(sprite_col),
    .active_mask(active_mask), .done_pulse(done_pulse), .player_hit(player_hit)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic start(input int x, input int y);
    start_valid = 1'b1;
    start_x = 10'(x);
    start_y = 10'(y);
  endtask

  // Drive a pixel/player position, expect the registered result one edge later.
  task automatic pix(input string tag, input int x, input int y, input int bx, input int by,
                     input bit on, input int r, input int c, input bit ph);
    pexp_t e;
    v_x = 10'(x);
    v_y = 10'(y);
    b_x = 10'(bx);
    b_y = 10'(by);
    e.on  = on;
    e.row = 4'(r);
    e.col = 4'(c);
    e.ph  = PH_EN ? ph : 1'b0;
    sb.push_back(e);
    step();
    e = sb.pop_front();
    chk({tag, ".on"},  32'(explosion_on), 32'(e.on));
    chk({tag, ".row"}, 32'(sprite_row),   32'(e.row));
    chk({tag, ".col"}, 32'(sprite_col),   32'(e.col));
    chk({tag, ".ph"},  32'(player_hit),   32'(e.ph));
    $display("pix %s v=(%0d,%0d) b=(%0d,%0d) on=%0d row=%0d col=%0d ph=%0d",
             tag, x, y, bx, by, explosion_on, sprite_row, sprite_col, player_hit);
  endtask

  task automatic state_chk(input string tag, input logic [3:0] mask, input bit done,
                           input bit ready);
    chk({tag, ".mask"},  32'(active_mask), 32'(mask));
    chk({tag, ".done"},  32'(done_pulse),  32'(done));
    chk({tag, ".ready"}, 32'(start_ready), 32'(ready));
    $display("state %s mask=%b done=%0d ready=%0d", tag, active_mask, done_pulse, start_ready);
  endtask

  initial begin
    // Power-on reset
    step();
    step();
    state_chk("reset", 4'b0000, 1'b0, 1'b1);
    chk("reset.on",  32'(explosion_on), 32'd0);
    chk("reset.row", 32'(sprite_row),   32'd0);
    chk("reset.col", 32'(sprite_col),   32'd0);
    chk("reset.ph",  32'(player_hit),   32'd0);
    reset = 1'b0;
    step();

    // Single blast at (160,160)
    start(160, 160);
    step();
    start_valid = 1'b0;
    state_chk("start0", 4'b0001, 1'b0, 1'b1);
    pix("arm_end",  208, 165, 600, 600, 1'b1, 5, 0, 1'b0);
    pix("arm_past", 224, 165, 600, 600, 1'b0, 0, 0, 1'b0);
    pix("vert",     165, 115, 600, 600, 1'b1, 3, 5, 1'b0);
    pix("ph_hit",   208, 165, 200, 168, 1'b1, 5, 0, 1'b1);
    pix("ph_miss",  208, 165, 210, 180, 1'b1, 5, 0, 1'b0);

    // Blast at the screen corner must not wrap
    start(0, 0);
    step();
    start_valid = 1'b0;
    state_chk("start1", 4'b0011, 1'b0, 1'b1);
    pix("nowrap", 1000, 5, 600, 600, 1'b0, 0, 0, 1'b0);
    pix("corner", 5, 40, 600, 600, 1'b1, 8, 5, 1'b0);

    // Asynchronous reset mid-operation
    reset = 1'b1;
    #2;
    state_chk("midreset", 4'b0000, 1'b0, 1'b1);
    chk("midreset.on", 32'(explosion_on), 32'd0);
    step();
    reset = 1'b0;
    step();

    // Five back-to-back requests into four slots
    start(160, 160);
    step();
    state_chk("fill0", 4'b0001, 1'b0, 1'b1);
    start(0, 0);
    step();
    state_chk("fill1", 4'b0011, 1'b0, 1'b1);
    start(176, 160);
    step();
    state_chk("fill2", 4'b0111, 1'b0, 1'b1);
    start(400, 400);
    step();
    state_chk("fill3", 4'b1111, 1'b0, 1'b0);
    start(800, 800);
    chk("fifth.ready", 32'(start_ready), 32'd0);
    step();
    start_valid = 1'b0;
    state_chk("fifth", 4'b1111, 1'b0, 1'b0);
    pix("dropped", 805, 806, 600, 600, 1'b0, 0, 0, 1'b0);
    pix("slot3",   410, 370, 600, 600, 1'b1, 2, 10, 1'b0);

    // First tick ages all slots without expiry
    tick = 1'b1;
    step();
    tick = 1'b0;
    state_chk("tick1", 4'b1111, 1'b0, 1'b0);

    // Expiry tick coincides with a request: dropped, then accepted next cycle
    tick = 1'b1;
    start(288, 288);
    chk("coinc.ready", 32'(start_ready), 32'd0);
    step();
    tick = 1'b0;
    state_chk("coinc", 4'b0000, 1'b1, 1'b1);
    step();
    start_valid = 1'b0;
    state_chk("retry", 4'b0001, 1'b0, 1'b1);
    pix("retry_px", 290, 295, 600, 600, 1'b1, 7, 2, 1'b0);

    // Two-tick lifetime for a single slot
    tick = 1'b1;
    step();
    tick = 1'b0;
    state_chk("life1", 4'b0001, 1'b0, 1'b1);
    tick = 1'b1;
    step();
    tick = 1'b0;
    state_chk("life2", 4'b0000, 1'b1, 1'b1);
    step();
    state_chk("life_after", 4'b0000, 1'b0, 1'b1);
    pix("gone", 290, 295, 600, 600, 1'b0, 0, 0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
